// File: rtl/ms_pkg.sv
// Shared types for the SoundDrive sample path: channel count, FIFO entry layout
// and the pacing FSM state encoding.
package ms_pkg;

  localparam int NUM_CHN = 4;
  localparam int ENTRY_W = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sd_state_t;

  typedef struct packed {
    logic [1:0] chn;
    logic [7:0] data;
  } sd_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock RAM FIFO with a combinational head read and registered
// level/full/empty that reflect the previous cycle's push and pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic                     clk32,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wp, rp;
  logic          push_ok, pop_ok;
  logic [LW-1:0] level_nxt;

  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  assign push_ok = push && (!full || pop) && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rp[AW-1:0]];

  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok)
      level_nxt = level + 1'b1;
    else if (!push_ok && pop_ok)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk32) begin
    if (push_ok)
      mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok)
        wp <= wp + 1'b1;
      if (pop_ok)
        rp <= rp + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/sd_sample_fifo.sv
// Buffered SoundDrive/Covox sample front-end: queues channel writes and replays
// them to the DAC stage in paced frames of at most one write per channel.
//
// state    | meaning
// ST_IDLE  | waiting for a rate tick (or a pending one) with data queued
// ST_BURST | popping one head entry per cycle until a channel repeats, FIFO empties or 4 sent
module sd_sample_fifo
  import ms_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 12
) (
  input  logic                   clk32,
  input  logic                   rst,
  input  logic                   wr_stb,
  input  logic [1:0]             wr_chn,
  input  logic [7:0]             wr_data,
  input  logic [CW-1:0]          rate_div,
  input  logic                   flush,
  output logic                   out_stb,
  output logic [1:0]             out_chn,
  output logic [7:0]             out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  sd_state_t            state, state_nxt;
  sd_entry_t            head;
  logic [NUM_CHN-1:0]   mask;
  logic [2:0]           nout;
  logic                 pend;
  logic [CW-1:0]        cnt;
  logic                 tick;
  logic                 head_ok;
  logic                 pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk32 (clk32),
    .rst   (rst),
    .push  (wr_stb),
    .pop   (pop),
    .flush (flush),
    .din   ({wr_chn, wr_data}),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Live compare so a lowered rate_div cuts the current period short.
  assign tick    = (cnt >= rate_div);
  assign head_ok = !empty && !mask[head.chn];

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (flush || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if ((tick || pend) && !empty) state_nxt = ST_BURST;
      ST_BURST: if (!head_ok || nout == 3'd3) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush)
      state_nxt = ST_IDLE;
  end

  always_comb begin
    pop = 1'b0;
    if (state == ST_BURST && head_ok && !flush)
      pop = 1'b1;
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      mask <= '0;
      nout <= '0;
      pend <= 1'b0;
    end else if (flush) begin
      mask <= '0;
      nout <= '0;
      pend <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (tick || pend) begin
        mask <= '0;
        nout <= '0;
        pend <= 1'b0;
      end
    end else begin
      if (tick)
        pend <= 1'b1;
      if (pop) begin
        mask[head.chn] <= 1'b1;
        nout           <= nout + 3'd1;
      end
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      out_stb  <= 1'b0;
      out_chn  <= '0;
      out_data <= '0;
    end else begin
      out_stb <= pop;
      if (pop) begin
        out_chn  <= head.chn;
        out_data <= head.data;
      end
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (flush)
      overflow <= 1'b0;
    else if (wr_stb && full && !pop)
      overflow <= 1'b1;
  end

endmodule

// File: tb/tb_sd_sample_fifo.sv
// Randomized bench for sd_sample_fifo against a queue-based frame model.
module tb_sd_sample_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 12;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk32 = 1'b0;
  logic          rst = 1'b0;
  logic          wr_stb = 1'b0;
  logic [1:0]    wr_chn = '0;
  logic [7:0]    wr_data = '0;
  logic [CW-1:0] rate_div = '0;
  logic          flush = 1'b0;
  logic          out_stb;
  logic [1:0]    out_chn;
  logic [7:0]    out_data;
  logic [LW-1:0] level;
  logic          full, empty, overflow;

  sd_sample_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk32    (clk32),
    .rst      (rst),
    .wr_stb   (wr_stb),
    .wr_chn   (wr_chn),
    .wr_data  (wr_data),
    .rate_div (rate_div),
    .flush    (flush),
    .out_stb  (out_stb),
    .out_chn  (out_chn),
    .out_data (out_data),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk32 = ~clk32;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the FIFO is a queue; a frame is a run of pops that stops on a
  // repeated channel, an empty queue or the fourth sample.
  logic [9:0] m_q[$];
  int         m_cnt;
  bit         m_in_frame;
  bit [3:0]   m_seen;
  int         m_nemit;
  bit         m_pend;
  bit         m_ovf;
  bit         m_stb;
  logic [1:0] m_chn;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_q.delete();
    m_cnt = 0; m_in_frame = 0; m_seen = 0; m_nemit = 0; m_pend = 0;
    m_ovf = 0; m_stb = 0; m_chn = 0; m_data = 0;
  endfunction

  function automatic void model_step();
    bit tick, was_full, popped;
    logic [9:0] e;
    if (flush) begin
      m_q.delete();
      m_cnt = 0; m_in_frame = 0; m_seen = 0; m_nemit = 0; m_pend = 0;
      m_ovf = 0; m_stb = 0;
      return;
    end
    tick = (m_cnt >= int'(rate_div));
    m_cnt = tick ? 0 : m_cnt + 1;
    was_full = (m_q.size() == DEPTH);
    popped = 0;
    m_stb = 0;
    if (!m_in_frame) begin
      if (tick || m_pend) begin
        m_pend = 0;
        if (m_q.size() != 0) begin
          m_in_frame = 1; m_seen = 0; m_nemit = 0;
        end
      end
    end else begin
      if (tick) m_pend = 1;
      if (m_q.size() != 0 && !m_seen[m_q[0][9:8]]) begin
        e = m_q.pop_front();
        popped = 1;
        m_stb = 1; m_chn = e[9:8]; m_data = e[7:0];
        m_seen[e[9:8]] = 1;
        m_nemit++;
        if (m_nemit == 4) m_in_frame = 0;
      end else begin
        m_in_frame = 0;
      end
    end
    if (wr_stb) begin
      if (!was_full || popped) m_q.push_back({wr_chn, wr_data});
      else m_ovf = 1;
    end
  endfunction

  task automatic compare_all();
    check_val("out_stb",  32'(out_stb),  32'(m_stb));
    check_val("out_chn",  32'(out_chn),  32'(m_chn));
    check_val("out_data", 32'(out_data), 32'(m_data));
    check_val("level",    32'(level),    32'(m_q.size()));
    check_val("full",     32'(full),     32'(m_q.size() == DEPTH));
    check_val("empty",    32'(empty),    32'(m_q.size() == 0));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic ws, input logic [1:0] ch, input logic [7:0] d, input logic fl);
    wr_stb = ws; wr_chn = ch; wr_data = d; flush = fl;
    @(posedge clk32);
    #1;
    if (rst) model_reset();
    else model_step();
    compare_all();
    wr_stb = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic run_random(input int n, input int wr_pct, input int flush_permille);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < wr_pct, 2'($urandom_range(3)), 8'($urandom_range(255)),
           $urandom_range(999) < flush_permille);
  endtask

  initial begin
    bit hit;
    model_reset();
    #2 rst = 1'b1;
    #2 compare_all();
    @(posedge clk32); @(posedge clk32);
    #1 rst = 1'b0;

    // single write at the fastest rate
    rate_div = '0;
    step(1'b1, 2'd2, 8'h80, 1'b0);
    idle(6);
    run_random(300, 33, 10);

    // frame grouping across two ticks
    step(1'b0, 2'd0, 8'd0, 1'b1);
    rate_div = CW'(99);
    step(1'b1, 2'd0, 8'h10, 1'b0);
    step(1'b1, 2'd1, 8'h20, 1'b0);
    step(1'b1, 2'd0, 8'h30, 1'b0);
    idle(220);

    // full frame of four then a leftover
    rate_div = CW'(30);
    for (int c = 0; c < 4; c++) step(1'b1, 2'(c), 8'(8'hA0 + c), 1'b0);
    step(1'b1, 2'd0, 8'hB0, 1'b0);
    idle(80);

    // overflow, flush, then refill and push against a full FIFO while it drains
    step(1'b0, 2'd0, 8'd0, 1'b1);
    rate_div = CW'(4095);
    for (int i = 0; i < 17; i++) step(1'b1, 2'(i % 4), 8'(i), 1'b0);
    step(1'b0, 2'd0, 8'd0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 2'(i % 4), 8'(8'h40 + i), 1'b0);
    rate_div = '0;
    for (int i = 0; i < 20; i++) step(1'b1, 2'(i % 4), 8'(8'hC0 + i), 1'b0);
    idle(40);

    // random rates, including live reductions
    for (int k = 0; k < 4; k++) begin
      rate_div = CW'($urandom_range(7));
      run_random(100, 50, 5);
    end
    rate_div = CW'($urandom_range(3));
    run_random(200, 75, 3);

    // async reset between the second and third pulse of a burst
    step(1'b0, 2'd0, 8'd0, 1'b1);
    rate_div = CW'(20);
    for (int i = 0; i < 6; i++) step(1'b1, 2'(i % 4), 8'(8'h50 + i), 1'b0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step(1'b0, 2'd0, 8'd0, 1'b0);
      if (m_stb && m_nemit == 2) hit = 1;
    end
    check_val("rst_wait", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step(1'b0, 2'd0, 8'd0, 1'b0);
    rst = 1'b0;
    idle(60);
    run_random(150, 40, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_sample_fifo.md
# sd_sample_fifo

Buffered sample front-end for the four SoundDrive/Covox channels. It sits between the ZX-bus port decoder and the DAC register stage. Each decoded channel write from the Z80 becomes one FIFO entry. Entries are replayed to the DAC stage in paced bursts, one sample frame per rate tick, so jittery CPU output loops reach the DACs at a fixed sample rate.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64.
- CW, 12, width of rate_div and of the tick counter.

Ports:
- clk32  in  1  system clock, 32 MHz. One clock domain.
- rst  in  1  asynchronous, active-high reset.
- wr_stb  in  1  one-cycle pulse per decoded channel write from the bus decoder.
- wr_chn  in  2  channel of the write: 0..3 = {a[6],a[4]}.
- wr_data  in  8  sample byte, raw bus data.
- rate_div  in  CW  clk32 cycles per tick, minus 1. 0 = tick every cycle.
- flush  in  1  synchronous clear of the FIFO and all pacing state.
- out_stb  out  1  one-cycle pulse: DAC channel write.
- out_chn  out  2  channel for out_stb; holds its value between pulses.
- out_data  out  8  sample for out_stb; holds its value between pulses.
- level  out  log2(DEPTH)+1  current entry count.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky; set when a write is dropped. Cleared by rst or flush.

## Operation
- Entry format: {chn[1:0], data[7:0]}.
- Circular buffer with read pointer rp and write pointer wp, each log2(DEPTH) bits plus a wrap bit.
- Push:
  - wr_stb && !full: write the entry at wp, then wp+1.
  - wr_stb && full && pop in the same cycle: the push is accepted.
  - wr_stb && full && no pop: the entry is dropped and overflow <= 1.
- Tick counter:
  - Counts 0..rate_div. When cnt >= rate_div: tick pulse, cnt <= 0.
  - The comparison uses the live rate_div, so a reduced rate_div takes effect immediately.
- FSM states are IDLE and BURST. Working registers: mask[3:0] (channels already emitted in the current burst), nout[2:0], pend.
- IDLE:
  - On (tick || pend) && !empty: go to BURST with mask=0, nout=0, pend=0.
  - On (tick || pend) && empty: pend <= 0. The frame is skipped and nothing is output.
- BURST, each cycle:
  - If empty, or mask[head.chn] is set: go to IDLE. The head entry stays for the next frame.
  - Otherwise: pop the head entry, drive out_stb=1 with out_chn/out_data from the entry, set mask[chn], increment nout.
  - If nout reaches 4: go to IDLE.
  - A tick arriving while in BURST sets pend.
- A frame therefore carries at most one write per channel and at most 4 entries. Write order is preserved.
- Data passes through unmodified. Sign conversion belongs to the DAC stage.
- flush:
  - Sets rp=wp=0, state=IDLE, mask=0, nout=0, pend=0, cnt=0, overflow=0.
  - Forces out_stb=0 that cycle.
  - A wr_stb in the same cycle is discarded.
- Reset values: out_stb=0, out_chn=0, out_data=0, level=0, full=0, empty=1, overflow=0, state IDLE, cnt=0.

## Timing
- Push latency: the entry is visible in level and empty on the cycle after wr_stb.
- Tick to first out_stb: 2 cycles. Tick at cycle t, BURST entered at t+1, registered out_stb at t+2.
- Within a burst, out_stb pulses on consecutive cycles, up to 4 of them.
- Minimum write-to-out latency with rate_div=0: 3 cycles.
- rate_div=0 with a steady writer: at most one burst is in progress; ticks coalesce through pend.
- level, full and empty are registered and reflect pushes and pops of the previous cycle.
- Reset is asynchronous: asserting rst mid-burst clears every output immediately. No partial frame is emitted after release.

## Structure
- A shared package (ms_pkg) holds the channel count (4), the entry width (10) and the FSM state enum.
- The storage is a natural sub-module: sync_fifo. It is a single-clock RAM FIFO with push/pop/flush, level, full and empty, and reads the head combinationally.
- The pacing FSM and tick counter stay in sd_sample_fifo.

## Test plan
- Single write, rate_div=0: push ch2/0x80 at cycle 0 -> out_stb at cycle 3 with out_chn=2, out_data=0x80; level returns to 0.
- Frame grouping, rate_div=99: push ch0/0x10, ch1/0x20, ch0/0x30 -> first tick emits ch0/0x10 then ch1/0x20 on consecutive cycles; ch0/0x30 is emitted at the next tick, 100 cycles later.
- Full frame: push ch0..ch3 and then ch0 again -> 4 pulses in one burst and the 5th entry on the next tick; level goes 5 -> 1 -> 0.
- Overflow, DEPTH=16, rate_div=4095: 17 pushes -> full=1, overflow=1, level=16, 17th entry absent. Flush -> level=0, overflow=0, empty=1.
- Simultaneous full push and pop: FIFO full during a burst pop plus wr_stb -> entry accepted, overflow stays 0, level unchanged.
- Async reset mid-burst: assert rst between the 2nd and 3rd pulse -> out_stb=0, out_chn/out_data=0, level=0 immediately; no pulses after release until new writes arrive.
